// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and bit-timing helpers.
// Imported by the transmit path and the baud generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int CNT_W = 16;

  function automatic int bit_cyc(
    input int sys_hz,
    input int baud
  );
    return sys_hz / baud;
  endfunction

  function automatic bit bit_cyc_ok(
    input int cyc
  );
    return (cyc >= 2) && (cyc < (1 << CNT_W));
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the host-side source and the UART transmitter.
// The source drives data_in/data_valid; the transmitter answers data_ready.
interface uart_tx_if #(
  parameter int W = 8
) ();

  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter with synchronous clear; ticks bit_end on the last
// cycle of each bit. Shared by the transmit and receive paths.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BIT_CYC = 16
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frames a handshaken byte as start, LSB-first data,
// optional parity and stop bit(s) on a registered serial line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int P_UART_WIDTH = 8,
  parameter int P_BAUD       = 9600,
  parameter int P_SYS_CLK_HZ = 500000000,
  parameter int P_PARITY     = 0,
  parameter int P_STOP_BITS  = 1
) (
  input  logic       CLK,
  input  logic       reset_n,
  uart_tx_if.slave   tx,
  output logic       serial_out,
  output logic       busy
);

  localparam int BIT_CYC = bit_cyc(P_SYS_CLK_HZ, P_BAUD);
  localparam int IDX_W   = 4;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(P_UART_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(P_STOP_BITS - 1);
  localparam bit   HAS_PAR = (P_PARITY != PAR_NONE);
  localparam logic ODD_INV = (P_PARITY == PAR_ODD);

  if (!bit_cyc_ok(BIT_CYC)) begin : g_bad_baud
    $error("uart_tx: bit period out of range");
  end
  if (P_UART_WIDTH < 5 || P_UART_WIDTH > 9) begin : g_bad_width
    $error("uart_tx: data width must be 5..9");
  end
  if (P_PARITY < PAR_NONE || P_PARITY > PAR_ODD) begin : g_bad_par
    $error("uart_tx: parity mode must be 0..2");
  end
  if (P_STOP_BITS < 1 || P_STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: stop bits must be 1 or 2");
  end

  state_t                  state, state_n;
  logic [P_UART_WIDTH-1:0] sh, sh_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic                    par, par_n;
  logic                    line_n;
  logic                    bit_end;
  logic                    xfer;

  assign tx.data_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign xfer          = tx.data_valid & tx.data_ready;

  uart_baud_gen #(
    .BIT_CYC (BIT_CYC)
  ) u_baud (
    .CLK     (CLK),
    .reset_n (reset_n),
    .clear   (state == IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    state_n = state;
    sh_n    = sh;
    idx_n   = idx;
    par_n   = par;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          state_n = START;
          sh_n    = tx.data_in;
          par_n   = (^tx.data_in) ^ ODD_INV;
          idx_n   = '0;
        end
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          sh_n = sh >> 1;
          if (idx == LAST_DATA) begin
            idx_n   = '0;
            state_n = HAS_PAR ? PARITY : STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (idx == LAST_STOP) begin
            idx_n   = '0;
            state_n = IDLE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The line level is registered from the next state so it
  // changes on the same edge that enters each bit slot.
  always_comb begin
    line_n = 1'b1;
    unique case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = sh_n[0];
      PARITY:  line_n = par_n;
      default: line_n = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sh         <= '0;
      idx        <= '0;
      par        <= 1'b0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      idx        <= idx_n;
      par        <= par_n;
      serial_out <= line_n;
    end
  end

endmodule
